acc_step_gen_multi: RTL

- Parametrised successor of the single-axis acceleration step generator.
- Drives NAXES stepper axes from a queue of constant-acceleration motion segments. Each segment carries a tick period, a tick count, and per-axis initial velocity and acceleration.
- Emits per-axis step/dir pulses from fixed-point position accumulators.
- Sits between the host command interface and the stepper driver outputs.

---
 rtl/acc_step_gen_multi.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/acc_step_gen_multi.sv
// acc_step_gen_multi
//   Multi-axis constant-acceleration step generator. Motion segments are
//   queued in a small FIFO; each segment runs for a number of ticks spaced
//   dt clock cycles apart. On every tick each axis adds its velocity into a
//   fixed-point position accumulator. The velocity is then updated by the
//   per-tick acceleration and clamped. A step pulse is emitted whenever the
//   integer part of an accumulator changes.
//
// Ports
//   clk, reset  : system clock, synchronous active-high reset
//   load        : push a segment (accepted only when ready=1)
//   ready       : FIFO not full
//   dt_val      : clock cycles per tick (0 behaves as 1)
//   steps_val   : ticks in the segment
//   v0_val      : per-axis initial velocity, axis i at [i*W +: W]
//   a_val       : per-axis per-tick acceleration, same packing
//   step, dir   : per-axis step pulse and held direction (1 = positive)
//   seg_done    : one-cycle pulse when a segment completes
//   busy        : engine active or segments pending
//   overflow    : sticky flag, a load arrived while ready=0
//
// Handshake: a segment is transferred on a rising clk edge where
// load && ready. ready depends only on the FIFO fill level held at the start
// of the cycle. It does not depend on load, or on a pop in the same cycle.
module acc_step_gen_multi #(
  parameter int NAXES  = 3,
  parameter int W      = 32,
  parameter int FRAC   = 16,
  parameter int QDEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  output logic               ready,
  input  logic [31:0]        dt_val,
  input  logic [31:0]        steps_val,
  input  logic [NAXES*W-1:0] v0_val,
  input  logic [NAXES*W-1:0] a_val,
  output logic [NAXES-1:0]   step,
  output logic [NAXES-1:0]   dir,
  output logic               seg_done,
  output logic               busy,
  output logic               overflow
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam int IW = W - FRAC;

  // Velocity limit: just under one step per tick.
  localparam logic signed [W:0] VMAX = (W+1)'((1 << FRAC) - 1);
  localparam logic signed [W:0] VMIN = -VMAX;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Segment FIFO storage
  logic [31:0]        fifo_dt_q    [QDEPTH];
  logic [31:0]        fifo_steps_q [QDEPTH];
  logic [NAXES*W-1:0] fifo_v0_q    [QDEPTH];
  logic [NAXES*W-1:0] fifo_a_q     [QDEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Engine state
  state_e                      state_q, state_d;
  logic [31:0]                 dtm1_q, dtm1_d;      // dt-1, dt=0 folded to 0
  logic [31:0]                 ticks_q, ticks_d;    // ticks remaining
  logic [31:0]                 period_q, period_d;  // cycles to next tick
  logic [NAXES-1:0][W-1:0]     v_q, v_d;
  logic [NAXES-1:0][W-1:0]     a_q, a_d;
  logic [NAXES-1:0][W-1:0]     acc_q, acc_d;
  logic [NAXES-1:0]            step_q, step_d;
  logic [NAXES-1:0]            dir_q, dir_d;
  logic                        seg_done_q, seg_done_d;
  logic                        overflow_q, overflow_d;

  // Per-axis datapath helpers
  logic [NAXES-1:0][W-1:0]     head_v0_ax;
  logic [NAXES-1:0][W-1:0]     head_a_ax;
  logic [NAXES-1:0][W-1:0]     acc_sum;
  logic [NAXES-1:0][W-1:0]     v_next;
  logic [NAXES-1:0][W-1:0]     v0_clamped;
  logic [NAXES-1:0][IW-1:0]    int_diff;

  logic [31:0] head_dt;
  logic [31:0] head_steps;
  logic [31:0] head_dtm1;
  logic        push;
  logic        pop;

  function automatic logic [W-1:0] sat_vel(input logic signed [W:0] x);
    logic [W-1:0] r;
    if (x > VMAX)      r = VMAX[W-1:0];
    else if (x < VMIN) r = VMIN[W-1:0];
    else               r = x[W-1:0];
    return r;
  endfunction

  assign ready      = (count_q != CW'(QDEPTH));
  assign push       = load && ready;
  assign pop        = (state_q == ST_IDLE) && (count_q != '0);

  assign head_dt    = fifo_dt_q[rd_ptr_q];
  assign head_steps = fifo_steps_q[rd_ptr_q];
  assign head_v0_ax = fifo_v0_q[rd_ptr_q];
  assign head_a_ax  = fifo_a_q[rd_ptr_q];
  assign head_dtm1  = (head_dt == 32'd0) ? 32'd0 : head_dt - 32'd1;

  // Velocities are always held within +/-VMAX, so the (W+1)-bit sums
  // below cannot overflow.
  always_comb begin
    acc_sum    = '0;
    v_next     = '0;
    v0_clamped = '0;
    int_diff   = '0;
    for (int i = 0; i < NAXES; i++) begin
      acc_sum[i]    = acc_q[i] + v_q[i];
      v_next[i]     = sat_vel($signed({v_q[i][W-1], v_q[i]}) +
                              $signed({a_q[i][W-1], a_q[i]}));
      v0_clamped[i] = sat_vel($signed({head_v0_ax[i][W-1], head_v0_ax[i]}));
      // Difference modulo 2^IW: accumulator wrap gives +/-1, not a jump.
      int_diff[i]   = acc_sum[i][W-1:FRAC] - acc_q[i][W-1:FRAC];
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    dtm1_d     = dtm1_q;
    ticks_d    = ticks_q;
    period_d   = period_q;
    v_d        = v_q;
    a_d        = a_q;
    acc_d      = acc_q;
    step_d     = '0;
    dir_d      = dir_q;
    seg_done_d = 1'b0;
    overflow_d = overflow_q | (load & ~ready);

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          // Segment parameters are captured as the entry leaves the FIFO.
          // A zero-length segment signals completion while in LOAD.
          state_d  = ST_LOAD;
          dtm1_d   = head_dtm1;
          period_d = head_dtm1;
          ticks_d  = head_steps;
          v_d      = v0_clamped;
          a_d      = head_a_ax;
          if (head_steps == 32'd0) seg_done_d = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = (ticks_q == 32'd0) ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (period_q == 32'd0) begin
          period_d = dtm1_q;
          ticks_d  = ticks_q - 32'd1;
          for (int i = 0; i < NAXES; i++) begin
            acc_d[i] = acc_sum[i];
            v_d[i]   = v_next[i];
            if (int_diff[i] != '0) begin
              step_d[i] = 1'b1;
              dir_d[i]  = (int_diff[i] == IW'(1));
            end
          end
          if (ticks_q == 32'd1) begin
            state_d    = ST_IDLE;
            seg_done_d = 1'b1;
          end
        end else begin
          period_d = period_q - 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      dtm1_q     <= '0;
      ticks_q    <= '0;
      period_q   <= '0;
      v_q        <= '0;
      a_q        <= '0;
      acc_q      <= '0;
      step_q     <= '0;
      dir_q      <= '0;
      seg_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      dtm1_q     <= dtm1_d;
      ticks_q    <= ticks_d;
      period_q   <= period_d;
      v_q        <= v_d;
      a_q        <= a_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      seg_done_q <= seg_done_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO payload needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dt_q[wr_ptr_q]    <= dt_val;
      fifo_steps_q[wr_ptr_q] <= steps_val;
      fifo_v0_q[wr_ptr_q]    <= v0_val;
      fifo_a_q[wr_ptr_q]     <= a_val;
    end
  end

  assign step     = step_q;
  assign dir      = dir_q;
  assign seg_done = seg_done_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != ST_IDLE) || (count_q != '0);

endmodule
